// File: rtl/alu_op_sequencer.sv
// ALU operand/control sequencer: accepts instruction words, reads operands
// from an internal register file, drives an external combinational ALU,
// writes the result back and presents it on a valid/ready result channel.
module alu_op_sequencer #(
  parameter int unsigned N    = 32,
  parameter int unsigned REGS = 8,
  parameter int unsigned AW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [3:0]    alu_ctrl,
  output logic [N-1:0]  src_A,
  output logic [N-1:0]  src_B,
  input  logic [N-1:0]  alu_result,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_data,
  output logic [AW-1:0] res_rd,
  output logic          res_err,
  input  logic [AW-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data
);

  localparam int unsigned IMM_W = 9;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] OP_LAST_ALU = 4'd5;
  localparam logic [3:0] OP_LDI      = 4'd15;

  state_t         state;
  logic [N-1:0]   regs [REGS];
  logic [AW-1:0]  rd_q;

  // Instruction field decode
  logic [3:0]     op;
  logic [AW-1:0]  rd, ra, rb;
  logic [N-1:0]   imm;
  logic           accept;
  logic           unused_bits;

  assign op          = instr[15:12];
  assign rd          = instr[11:9];
  assign ra          = instr[8:6];
  assign rb          = instr[5:3];
  assign imm         = {{(N-IMM_W){1'b0}}, instr[8:0]};
  assign accept      = instr_valid && instr_ready;
  assign unused_bits = ^instr[2:0];

  // Debug read port sees the register file directly
  assign dbg_data = regs[dbg_addr];

  // Sequencer FSM, register file and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      rd_q        <= '0;
      alu_ctrl    <= '0;
      src_A       <= '0;
      src_B       <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_rd      <= '0;
      res_err     <= 1'b0;
      for (int i = 0; i < int'(REGS); i++) regs[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rd_q        <= rd;
            instr_ready <= 1'b0;
            if (op <= OP_LAST_ALU) begin
              // Operands read here already include every earlier writeback
              alu_ctrl <= op;
              src_A    <= regs[ra];
              src_B    <= regs[rb];
              state    <= EXEC;
            end else if (op == OP_LDI) begin
              regs[rd]  <= imm;
              res_data  <= imm;
              res_rd    <= rd;
              res_err   <= 1'b0;
              res_valid <= 1'b1;
              state     <= RESP;
            end else begin
              res_data  <= '0;
              res_rd    <= rd;
              res_err   <= 1'b1;
              res_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        EXEC: begin
          regs[rd_q] <= alu_result;
          res_data   <= alu_result;
          res_rd     <= rd_q;
          res_err    <= 1'b0;
          res_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
          res_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule
